// File: rtl/dac_config_sequencer_if.sv
// Command and dac_driver-side bundle of the DAC configuration sequencer.
// The host/register bank uses the master modport; the sequencer uses the slave modport.
interface dac_config_sequencer_if #(
  parameter int FIELD_W = 256,
  parameter int GPIO_W  = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_field;
  logic [FIELD_W-1:0] cmd_data;
  logic [GPIO_W-1:0]  gpio_ctrl;
  logic               select_out;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output cmd_valid, cmd_field, cmd_data,
    input  cmd_ready, gpio_ctrl, select_out, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_field, cmd_data,
    output cmd_ready, gpio_ctrl, select_out, busy, done, err
  );
endinterface

// File: rtl/dac_config_sequencer.sv
// Serial configuration master for dac_driver: shifts one command's value out on
// gpio_ctrl sdata while pulsing the target field's serial clock with fixed timing.
module dac_config_sequencer #(
  parameter int FIELD_W                  = 256,
  parameter int SCALAR_PULSES            = 8,
  parameter int SETUP_CYC                = 2,
  parameter int HIGH_CYC                 = 2,
  parameter int HOLD_CYC                 = 2,
  parameter int GPIO_W                   = 16,
  parameter int SDATA_BIT                = 0,
  parameter int CYCLE_COUNT_CLK_BIT      = 1,
  parameter int MASK_CLK_BIT             = 2,
  parameter int PRE_DELAY_CYCLE_CLK_BIT  = 3,
  parameter int POST_DELAY_CYCLE_CLK_BIT = 4,
  parameter int LOCKING_WAVEFORM_CLK_BIT = 5,
  parameter int MUX_SET_CLK_BIT          = 6,
  parameter int MASK_ENABLE_CLK_BIT      = 7
) (
  input logic clk,
  input logic rst,
  dac_config_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int PH_MAX_SH = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int PH_MAX    = (PH_MAX_SH > HOLD_CYC) ? PH_MAX_SH : HOLD_CYC;
  localparam int PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] HIGH_LAST  = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYC - 1);
  localparam logic [8:0]      WIDE_LAST   = 9'(FIELD_W - 1);
  localparam logic [8:0]      SCALAR_LAST = 9'(SCALAR_PULSES - 1);

  logic [2:0]         state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [8:0]         bit_q, bit_d;
  logic [2:0]         field_q, field_d;
  logic [FIELD_W-1:0] data_q, data_d;
  logic               clk_on_q, clk_on_d;
  logic               ready_q, ready_d;
  logic               select_q, select_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [GPIO_W-1:0]  gpio_q, gpio_d;

  logic               is_wide;
  logic [8:0]         last_bit;
  logic [GPIO_W-1:0]  clk_mask;

  assign is_wide  = (field_q < 3'd5);
  assign last_bit = is_wide ? WIDE_LAST : SCALAR_LAST;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    field_d  = field_q;
    data_d   = data_q;
    clk_on_d = clk_on_q;
    ready_d  = ready_q;
    select_d = select_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          if (bus.cmd_field == 3'd7) begin
            err_d = 1'b1;
          end else begin
            state_d  = ST_SETUP;
            phase_d  = '0;
            bit_d    = '0;
            field_d  = bus.cmd_field;
            data_d   = bus.cmd_data;
            clk_on_d = 1'b0;
            ready_d  = 1'b0;
            select_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d  = ST_HIGH;
          phase_d  = '0;
          clk_on_d = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_q == HIGH_LAST) begin
          state_d  = ST_HOLD;
          phase_d  = '0;
          clk_on_d = 1'b0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          if (bit_q == last_bit) begin
            state_d  = ST_DONE;
            select_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            state_d = ST_SETUP;
            phase_d = '0;
            bit_d   = bit_q + 9'd1;
            // Scalar fields repeat bit 0 on every pulse, so only wide fields shift.
            if (is_wide) begin
              data_d = data_q >> 1;
            end
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        clk_on_d = 1'b0;
        ready_d  = 1'b1;
        select_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    clk_mask = '0;
    case (field_d)
      3'd0:    clk_mask[CYCLE_COUNT_CLK_BIT]      = 1'b1;
      3'd1:    clk_mask[MASK_CLK_BIT]             = 1'b1;
      3'd2:    clk_mask[PRE_DELAY_CYCLE_CLK_BIT]  = 1'b1;
      3'd3:    clk_mask[POST_DELAY_CYCLE_CLK_BIT] = 1'b1;
      3'd4:    clk_mask[LOCKING_WAVEFORM_CLK_BIT] = 1'b1;
      3'd5:    clk_mask[MUX_SET_CLK_BIT]          = 1'b1;
      3'd6:    clk_mask[MASK_ENABLE_CLK_BIT]      = 1'b1;
      default: clk_mask = '0;
    endcase

    // sdata follows the low data bit only while a command owns the bus.
    gpio_d            = clk_on_d ? clk_mask : '0;
    gpio_d[SDATA_BIT] = data_d[0] & select_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      field_q  <= '0;
      data_q   <= '0;
      clk_on_q <= 1'b0;
      ready_q  <= 1'b1;
      select_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      gpio_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      field_q  <= field_d;
      data_q   <= data_d;
      clk_on_q <= clk_on_d;
      ready_q  <= ready_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      gpio_q   <= gpio_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.gpio_ctrl  = gpio_q;
  assign bus.select_out = select_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_dac_config_sequencer.sv
// Scoreboard bench for dac_config_sequencer: the driver queues expected pulses and
// events per command, a negedge monitor pops and compares them as they appear.
module tb_dac_config_sequencer;
  localparam int FIELD_W   = 256;
  localparam int GPIO_W    = 16;
  localparam int SETUP_CYC = 2;
  localparam int HIGH_CYC  = 2;
  localparam int HOLD_CYC  = 2;
  localparam int P         = SETUP_CYC + HIGH_CYC + HOLD_CYC;
  localparam int CLK_BIT [7] = '{1, 2, 3, 4, 5, 6, 7};

  typedef struct {
    int   idx;
    logic sd;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_prev = 1'b1;
  int   cyc = 0;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  pulse_t pulse_q[$];
  int     done_q[$];
  int     err_q[$];
  int     sel_start_q[$];
  int     sel_end_q[$];

  logic [6:0] prev_clk = '0;
  logic [6:0] cur_mask = '0;
  logic       prev_sel = 1'b0;
  logic       prev_sd = 1'b0;
  int         last_change = -100;
  int         last_fall = -100;
  int         high_len = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  dac_config_sequencer_if #(.FIELD_W(FIELD_W), .GPIO_W(GPIO_W)) bus ();

  dac_config_sequencer #(.FIELD_W(FIELD_W), .GPIO_W(GPIO_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mon_step();
    logic [6:0] cb;
    logic       sd;
    pulse_t     p;
    int         e;
    cb = bus.gpio_ctrl[7:1];
    sd = bus.gpio_ctrl[0];
    if (rst || rst_prev) begin
      prev_clk = cb;
      prev_sel = bus.select_out;
      prev_sd = sd;
      last_change = -100;
      last_fall = -100;
      high_len = 0;
      return;
    end
    if (sd !== prev_sd) begin
      chk("hold_ok", 64'(cyc - last_fall >= HOLD_CYC), 64'd1);
      last_change = cyc;
    end
    if (cb != 0 && prev_clk == 0) begin
      if (pulse_q.size() == 0) begin
        chk("pulse_extra", 64'd1, 64'd0);
        cur_mask = cb;
      end else begin
        p = pulse_q.pop_front();
        cur_mask = 7'(1 << (p.idx - 1));
        chk("sdata", 64'(sd), 64'(p.sd));
        chk("setup_ok", 64'(cyc - last_change >= SETUP_CYC), 64'd1);
        chk("unused_bits", 64'(bus.gpio_ctrl[15:8]), 64'd0);
      end
      high_len = 0;
    end
    if (cb != 0) begin
      chk("clk_sel", 64'(cb), 64'(cur_mask));
      high_len++;
    end
    if (cb == 0 && prev_clk != 0) begin
      chk("high_len", 64'(high_len), 64'(HIGH_CYC));
      last_fall = cyc;
    end
    if (bus.select_out && !prev_sel) begin
      if (sel_start_q.size() == 0) chk("sel_extra", 64'd1, 64'd0);
      else begin
        e = sel_start_q.pop_front();
        chk("sel_start", 64'(cyc), 64'(e));
        chk("busy_on", 64'(bus.busy), 64'd1);
        chk("rdy_off", 64'(bus.cmd_ready), 64'd0);
      end
    end
    if (!bus.select_out && prev_sel) begin
      if (sel_end_q.size() == 0) chk("sel_fall_extra", 64'd1, 64'd0);
      else begin
        e = sel_end_q.pop_front();
        chk("sel_end", 64'(cyc - 1), 64'(e));
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) chk("done_extra", 64'd1, 64'd0);
      else begin
        e = done_q.pop_front();
        chk("done_cyc", 64'(cyc), 64'(e));
        chk("done_rdy", 64'(bus.cmd_ready), 64'd0);
        chk("done_busy", 64'(bus.busy), 64'd0);
        chk("done_gpio", 64'(bus.gpio_ctrl), 64'd0);
      end
    end
    if (bus.err) begin
      if (err_q.size() == 0) chk("err_extra", 64'd1, 64'd0);
      else begin
        e = err_q.pop_front();
        chk("err_cyc", 64'(cyc), 64'(e));
        chk("err_rdy", 64'(bus.cmd_ready), 64'd1);
      end
    end
    prev_clk = cb;
    prev_sel = bus.select_out;
    prev_sd = sd;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_step();
    end
  end

  // Called and returns at posedge+1; drives one command and queues its expectations.
  task automatic send(input logic [2:0] f, input logic [255:0] d, input bit hold,
                      input bit chk_t, input int exp_t, output int t);
    int     budget;
    int     n;
    pulse_t p;
    budget = 0;
    bus.cmd_field = f;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && budget < 4000) begin
      @(posedge clk); #1;
      budget++;
    end
    t = cyc;
    if (budget >= 4000) begin
      chk("ready_timeout", 64'd0, 64'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (chk_t) chk("accept_cyc", 64'(t), 64'(exp_t));
    $display("cmd field %0d data %0h accepted at cycle %0d", f, d[31:0], t);
    if (f == 3'd7) begin
      err_q.push_back(t + 1);
    end else begin
      n = (f >= 3'd5) ? 8 : FIELD_W;
      for (int k = 0; k < n; k++) begin
        p.idx = CLK_BIT[f];
        p.sd  = (f >= 3'd5) ? d[0] : d[k];
        pulse_q.push_back(p);
      end
      sel_start_q.push_back(t + 1);
      sel_end_q.push_back(t + n * P);
      done_q.push_back(t + n * P + 1);
    end
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((pulse_q.size() + done_q.size() + err_q.size() + sel_end_q.size()) != 0 && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 2000) chk("idle_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, b;
    logic [255:0] rd;
    bus.cmd_valid = 1'b0;
    bus.cmd_field = '0;
    bus.cmd_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio", 64'(bus.gpio_ctrl), 64'd0);
    chk("rst_sel", 64'(bus.select_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_rdy", 64'(bus.cmd_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    send(3'd0, 256'd10, 1'b0, 1'b0, 0, t);
    wait_idle();

    send(3'd5, 256'd1, 1'b0, 1'b0, 0, t);
    wait_idle();
    send(3'd5, 256'hFFFE, 1'b0, 1'b0, 0, t);
    wait_idle();

    send(3'd1, {{8{16'h0000}}, {8{16'hFFFF}}}, 1'b0, 1'b0, 0, t);
    wait_idle();

    send(3'd2, 256'd2, 1'b1, 1'b0, 0, t1);
    send(3'd3, 256'd2, 1'b0, 1'b1, t1 + FIELD_W * P + 2, t2);
    wait_idle();

    send(3'd7, {256{1'b1}}, 1'b0, 1'b0, 0, t);
    chk("f7_gpio", 64'(bus.gpio_ctrl), 64'd0);
    chk("f7_sel", 64'(bus.select_out), 64'd0);
    chk("f7_busy", 64'(bus.busy), 64'd0);
    chk("f7_rdy", 64'(bus.cmd_ready), 64'd1);
    wait_idle();

    rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send(3'd4, rd, 1'b0, 1'b0, 0, t);
    b = 0;
    while (cyc < t + 100 * P + SETUP_CYC + 1 && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    chk("pre_rst_clk", 64'(bus.gpio_ctrl[5]), 64'd1);
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_field = 3'd6;
    pulse_q.delete();
    done_q.delete();
    err_q.delete();
    sel_start_q.delete();
    sel_end_q.delete();
    @(posedge clk); #1;
    $display("reset asserted mid-shift at cycle %0d", cyc - 1);
    chk("mid_rst_gpio", 64'(bus.gpio_ctrl), 64'd0);
    chk("mid_rst_sel", 64'(bus.select_out), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rdy", 64'(bus.cmd_ready), 64'd1);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_sel", 64'(bus.select_out), 64'd0);

    send(3'd6, 256'd1, 1'b0, 1'b0, 0, t);
    wait_idle();

    chk("leftover", 64'(pulse_q.size() + done_q.size() + err_q.size()
                        + sel_start_q.size() + sel_end_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
